// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
// -----------------------------------------------------------------------------
// Turns the main-control ALUOp and the RISC-V {funct7,funct3} into the 3-bit
// ALU control code (000 OR, 001 AND, 010 ADD, 011 SUB, 100 MUL). A MUL is
// executed here as an iterative shift-add, BITS_PER_CYCLE multiplier bits per
// cycle, and the pipeline is stalled until the product is ready.
//
// Ports:
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous, active-low reset
//   valid_i     instruction in decode is valid
//   ALUOp_i     operation class from main control
//   funct_i     {funct7[6:0], funct3[2:0]}
//   data1_i     rs1 operand (multiplicand)
//   data2_i     rs2 operand (multiplier)
//   ALUCtrl_o   ALU control code
//   stall_o     hold PC and IF/ID while a multiply is in progress
//   product_o   low 32 bits of data1_i*data2_i, held until the next multiply
//   mul_done_o  one-cycle pulse, product_o valid for writeback
//
// Build option:
//   MUL_EARLY_OUT_EN  when defined, RUN ends as soon as the remaining multiplier
//                     is zero instead of always running 32/BITS_PER_CYCLE steps.
// -----------------------------------------------------------------------------
module alu_ctrl_seq #(
  parameter int BITS_PER_CYCLE = 1  // legal values: 1, 2, 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [9:0]  funct_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic [2:0]  ALUCtrl_o,
  output logic        stall_o,
  output logic [31:0] product_o,
  output logic        mul_done_o
);

  localparam int         N          = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT   = 5'(N - 1);
  localparam logic [3:0] DIGIT_MASK = 4'((1 << BITS_PER_CYCLE) - 1);

  localparam logic [2:0] CTRL_OR  = 3'b000;
  localparam logic [2:0] CTRL_AND = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b011;
  localparam logic [2:0] CTRL_MUL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [4:0]  r_count;
  logic [31:0] r_product;

  logic [2:0]  w_decode;
  logic [3:0]  w_digit;
  logic [31:0] w_acc_next;
  logic [31:0] w_mplier_next;
  logic        w_last_step;
  logic        w_start;

  // ALUOp / funct decode into the ALU control code.
  function automatic logic [2:0] decode_ctrl(input logic [1:0] aluop, input logic [9:0] funct);
    logic [2:0] ctrl;
    ctrl = CTRL_ADD;
    case (aluop)
      2'b00: ctrl = CTRL_ADD;
      2'b01: ctrl = CTRL_SUB;
      2'b11: ctrl = CTRL_ADD;
      2'b10: begin
        case (funct)
          10'b0000000_110: ctrl = CTRL_OR;
          10'b0000000_111: ctrl = CTRL_AND;
          10'b0000000_000: ctrl = CTRL_ADD;
          10'b0100000_000: ctrl = CTRL_SUB;
          10'b0000001_000: ctrl = CTRL_MUL;
          default:         ctrl = CTRL_ADD;
        endcase
      end
      default: ctrl = CTRL_ADD;
    endcase
    return ctrl;
  endfunction

  // digit * mcand as a small shift-add; digit bits above BITS_PER_CYCLE are masked to zero.
  function automatic logic [31:0] partial_product(input logic [31:0] mcand, input logic [3:0] digit);
    logic [31:0] sum;
    sum = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (digit[i]) begin
        sum = sum + (mcand << i);
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  assign w_decode      = decode_ctrl(ALUOp_i, funct_i);
  assign w_digit       = r_mplier[3:0] & DIGIT_MASK;
  assign w_acc_next    = r_acc + partial_product(r_mcand, w_digit);
  assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;
  assign w_start       = valid_i && (w_decode == CTRL_MUL);
  assign product_o     = r_product;

`ifdef MUL_EARLY_OUT_EN
  // Remaining multiplier bits all zero: further steps would add nothing.
  assign w_last_step = (r_count == LAST_CNT) || (w_mplier_next == 32'd0);
`else
  assign w_last_step = (r_count == LAST_CNT);
`endif

  // Next-state and output decode; reset forces the quiet ADD/no-stall view.
  always_comb begin
    w_next_state = r_state;
    ALUCtrl_o    = CTRL_ADD;
    stall_o      = 1'b0;
    mul_done_o   = 1'b0;
    if (!rst_i) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          ALUCtrl_o = w_decode;
          if (w_start) begin
            // Stall in the same cycle so the MUL stays in decode.
            stall_o      = 1'b1;
            w_next_state = S_RUN;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_RUN: begin
          ALUCtrl_o = CTRL_MUL;
          stall_o   = 1'b1;
          if (w_last_step) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_RUN;
          end
        end
        S_DONE: begin
          // Stall drops here, so the stalled MUL leaves decode without restarting.
          ALUCtrl_o    = CTRL_MUL;
          mul_done_o   = 1'b1;
          w_next_state = S_IDLE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // State register and shift-add datapath.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_mcand   <= 32'd0;
      r_mplier  <= 32'd0;
      r_acc     <= 32'd0;
      r_count   <= 5'd0;
      r_product <= 32'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_acc    <= 32'd0;
            r_count  <= 5'd0;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= w_mplier_next;
          r_count  <= r_count + 5'd1;
          // Capture on the final step so product_o is valid throughout DONE.
          if (w_last_step) begin
            r_product <= w_acc_next;
          end
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq
// Self-checking bench for alu_ctrl_seq: decode table, directed and random
// multiplies against a plain-arithmetic reference, reset behaviour.
module tb_alu_ctrl_seq;

  localparam int BPC = 1;
  localparam int N   = 32 / BPC;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [1:0]  ALUOp_i;
  logic [9:0]  funct_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [2:0]  ALUCtrl_o;
  logic        stall_o;
  logic [31:0] product_o;
  logic        mul_done_o;

  int num_checks = 0;
  int num_fail   = 0;

  alu_ctrl_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ALUOp_i    (ALUOp_i),
    .funct_i    (funct_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .ALUCtrl_o  (ALUCtrl_o),
    .stall_o    (stall_o),
    .product_o  (product_o),
    .mul_done_o (mul_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic logic [2:0] ref_decode(input logic [1:0] aluop, input logic [9:0] funct);
    if (aluop == 2'b00) return 3'b010;
    if (aluop == 2'b01) return 3'b011;
    if (aluop == 2'b11) return 3'b010;
    if (funct == 10'b0000000110) return 3'b000;
    if (funct == 10'b0000000111) return 3'b001;
    if (funct == 10'b0000000000) return 3'b010;
    if (funct == 10'b0100000000) return 3'b011;
    if (funct == 10'b0000001000) return 3'b100;
    return 3'b010;
  endfunction

  // Number of RUN cycles a multiply by b takes.
  function automatic int ref_run_cycles(input logic [31:0] b);
    int k;
`ifdef MUL_EARLY_OUT_EN
    k = 1;
    while (k < N && (b >> (k * BPC)) != 32'd0) k++;
`else
    k = N;
`endif
    return k;
  endfunction

  typedef struct {
    logic [1:0] aluop;
    logic [9:0] funct;
    logic [2:0] exp;
  } dec_vec_t;

  dec_vec_t dec_tab[9];

  // Issue a MUL from IDLE and follow it to mul_done_o; optionally wiggle the operands mid-run.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit scramble, input string name);
    int          exp_done;
    logic [31:0] exp_prod;
    int          done_cyc;
    int          stall_cnt;
    logic [31:0] got_prod;
    logic [2:0]  got_ctrl;
    exp_done  = ref_run_cycles(b) + 1;
    exp_prod  = a * b;
    done_cyc  = -1;
    stall_cnt = 0;
    got_prod  = 32'd0;
    got_ctrl  = 3'd0;
    valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 10'b0000001000;
    data1_i = a; data2_i = b;
    for (int cyc = 0; cyc < N + 8; cyc++) begin
      @(negedge clk_i);
      if (stall_o) stall_cnt++;
      if (mul_done_o) begin
        done_cyc = cyc;
        got_prod = product_o;
        got_ctrl = ALUCtrl_o;
      end
      @(posedge clk_i); #1;
      if (done_cyc >= 0) break;
      if (scramble) begin
        data1_i = $urandom;
        data2_i = $urandom;
      end
    end
    valid_i = 1'b0;
    check({name, " done_cycle"}, done_cyc, exp_done);
    check({name, " stall_cycles"}, stall_cnt, exp_done);
    check({name, " product"}, got_prod, exp_prod);
    check({name, " ctrl_at_done"}, {29'd0, got_ctrl}, 32'd4);
    check({name, " product_hold"}, product_o, exp_prod);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_cyc;
    int pulses;
    int stalls;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    logic [9:0]  rf;

    dec_tab[0] = '{2'b10, 10'b0000000110, 3'b000};
    dec_tab[1] = '{2'b10, 10'b0000000111, 3'b001};
    dec_tab[2] = '{2'b10, 10'b0000000000, 3'b010};
    dec_tab[3] = '{2'b10, 10'b0100000000, 3'b011};
    dec_tab[4] = '{2'b10, 10'b0000001000, 3'b100};
    dec_tab[5] = '{2'b00, 10'b0000001000, 3'b010};
    dec_tab[6] = '{2'b01, 10'b0000000000, 3'b011};
    dec_tab[7] = '{2'b11, 10'b0000001000, 3'b010};
    dec_tab[8] = '{2'b10, 10'b0000000101, 3'b010};

    // Reset held with a valid MUL in decode.
    rst_i = 1'b0; valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 10'b0000001000;
    data1_i = 32'd7; data2_i = 32'd6;
    @(posedge clk_i); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("reset stall", {31'd0, stall_o}, 32'd0);
      check("reset ctrl", {29'd0, ALUCtrl_o}, 32'd2);
      check("reset product", product_o, 32'd0);
      check("reset mul_done", {31'd0, mul_done_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    rst_i   = 1'b1;
    @(posedge clk_i); #1;

    // Decode table, with and without valid_i.
    for (int i = 0; i < 9; i++) begin
      ALUOp_i = dec_tab[i].aluop; funct_i = dec_tab[i].funct; valid_i = 1'b1;
      #1;
      check($sformatf("decode[%0d] ctrl", i), {29'd0, ALUCtrl_o}, {29'd0, dec_tab[i].exp});
      check($sformatf("decode[%0d] stall", i), {31'd0, stall_o}, {31'd0, dec_tab[i].exp == 3'b100});
      valid_i = 1'b0;
      #1;
      check($sformatf("decode[%0d] ctrl_novalid", i), {29'd0, ALUCtrl_o}, {29'd0, dec_tab[i].exp});
      check($sformatf("decode[%0d] stall_novalid", i), {31'd0, stall_o}, 32'd0);
      @(posedge clk_i); #1;
    end

    // Directed multiplies; the wrap cases run back to back.
    run_mul(32'd7, 32'd6, 1'b0, "mul_7x6");
    run_mul(32'hFFFFFFFF, 32'd2, 1'b0, "mul_wrap_ff_x2");
    run_mul(32'h00010000, 32'h00010000, 1'b0, "mul_wrap_64k_sq");
    run_mul(32'h00001234, 32'd0, 1'b0, "mul_1234x0");
    run_mul(32'd5, 32'd1, 1'b0, "mul_5x1");
`ifdef MUL_EARLY_OUT_EN
    run_mul(32'h00001234, 32'd0, 1'b0, "early_zero");
    run_mul(32'd5, 32'd1, 1'b0, "early_one");
`endif

    // Reset in the middle of RUN: no completion pulse, then a fresh MUL works.
    rst_cyc = (N > 10) ? 10 : N / 2;
    valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 10'b0000001000;
    data1_i = 32'hDEADBEEF; data2_i = 32'hFFFFFFFF;
    for (int cyc = 0; cyc < rst_cyc; cyc++) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midreset stall", {31'd0, stall_o}, 32'd0);
    check("midreset ctrl", {29'd0, ALUCtrl_o}, 32'd2);
    @(posedge clk_i); #1;
    rst_i = 1'b1; valid_i = 1'b0;
    pulses = 0; stalls = 0;
    for (int cyc = 0; cyc < N + 4; cyc++) begin
      @(negedge clk_i);
      if (mul_done_o) pulses++;
      if (stall_o) stalls++;
      @(posedge clk_i); #1;
    end
    check("midreset no_done_pulse", pulses, 32'd0);
    check("midreset no_stall_after", stalls, 32'd0);
    check("midreset product_cleared", product_o, 32'd0);
    run_mul(32'd3, 32'd5, 1'b0, "mul_3x5_after_reset");

    // Random multiplies with operands changing during RUN.
    for (int i = 0; i < 14; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 255));
        1: rb = 32'd0;
        default: rb = $urandom;
      endcase
      run_mul(ra, rb, 1'b1, $sformatf("rand_mul[%0d]", i));
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk_i); #1;
      end
    end

    // Random decode with valid_i low.
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom);
      rf  = ($urandom_range(0, 1) == 1) ? {7'b0000000, 3'($urandom)} : 10'($urandom);
      ALUOp_i = rop; funct_i = rf; valid_i = 1'b0;
      #1;
      check($sformatf("rand_decode[%0d]", i), {29'd0, ALUCtrl_o}, {29'd0, ref_decode(rop, rf)});
      @(posedge clk_i); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Produces the 3-bit ALU control code consumed by the CPU's ALU.
- Encoding: 000 OR, 001 AND, 010 ADD, 011 SUB, 100 MUL.
- Decodes ALUOp plus RISC-V funct7/funct3 into that code.
- MUL is executed as an iterative shift-add sequence in this block, with a stall to the pipeline control.
- Sits between the main Control/instruction decode stage and the ALU/writeback mux.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per cycle. Legal values: 1, 2, 4. Run length N = 32/BITS_PER_CYCLE.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-low reset.
- valid_i  input  1  instruction in decode is valid.
- ALUOp_i  input  2  ALU operation class from main control.
- funct_i  input  10  {funct7[6:0], funct3[2:0]}.
- data1_i  input  32  rs1 operand.
- data2_i  input  32  rs2 operand.
- ALUCtrl_o  output  3  ALU control code.
- stall_o  output  1  hold PC and IF/ID while multiply is in progress.
- product_o  output  32  low 32 bits of data1_i*data2_i (unsigned/mod 2^32).
- mul_done_o  output  1  one-cycle pulse: product_o valid for writeback.

Behaviour:
- Decode (combinational in IDLE):
  - ALUOp 00 → 010 (ADD, load/store).
  - ALUOp 01 → 011 (SUB, branch compare).
  - ALUOp 11 → 010 (ADDI).
  - ALUOp 10 (R-type), by {funct7,funct3}:
    - 0000000_110 → 000 (OR)
    - 0000000_111 → 001 (AND)
    - 0000000_000 → 010 (ADD)
    - 0100000_000 → 011 (SUB)
    - 0000001_000 → 100 (MUL)
    - any other → 010 (ADD)
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - valid_i=1 and decode=MUL: stall_o=1 combinationally in this same cycle.
  - Latch multiplicand=data1_i, multiplier=data2_i, accumulator=0, count=0; next state RUN.
  - Otherwise stay in IDLE with stall_o=0.
- RUN:
  - Each cycle: add (multiplier low BITS_PER_CYCLE bits × multiplicand) to accumulator.
  - Shift multiplicand left by BITS_PER_CYCLE; shift multiplier right by BITS_PER_CYCLE; count+1.
  - All arithmetic is 32-bit; overflow discarded (mod 2^32).
  - stall_o=1; ALUCtrl_o held at 100.
  - When count reaches N-1, next state DONE.
- DONE:
  - stall_o=0; mul_done_o=1; product_o=accumulator; ALUCtrl_o=100.
  - Unconditionally go to IDLE next cycle. The stalled MUL still on valid_i is consumed here and does not restart.
- Latency: MUL presented at cycle 0 → stall_o high cycles 0..N → mul_done_o at cycle N+1 → IDLE at N+2.
- product_o holds its last value until the next DONE.
- Operand changes during RUN are ignored; operands are captured at the IDLE→RUN transition.
- valid_i=0 in IDLE: ALUCtrl_o still shows the decode; stall_o=0.
- Back-to-back MULs: the second MUL starts at its IDLE cycle (N+2) with no extra bubble.
- Reset (rst_i=0 at a clock edge):
  - State IDLE, accumulator=0, count=0, product_o=0, mul_done_o=0.
  - stall_o=0 while rst_i=0, regardless of inputs.
  - ALUCtrl_o=010 while rst_i=0.
  - Reset mid-RUN aborts the multiply with no mul_done_o pulse.

Optional Feature:
- Macro: MUL_EARLY_OUT_EN.
- Defined: in RUN, if the remaining multiplier is zero after the current step, go to DONE next cycle regardless of count. A zero data2_i at latch therefore completes after 1 RUN cycle (mul_done_o at cycle 2).
- Undefined: always exactly N RUN cycles.
- product_o value is identical in both builds.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with valid_i=1 and a MUL instruction → stall_o=0, ALUCtrl_o=010, product_o=0, mul_done_o=0.
- Decode sweep (valid_i=1): ALUOp=10 with funct 0000000_110/111/000, 0100000_000, 0000001_000 → 000/001/010/011/100; ALUOp 00/01/11 → 010/011/010; ALUOp=10, funct 0000000_101 → 010.
- BITS_PER_CYCLE=1, MUL 7×6 → stall_o high 33 cycles, mul_done_o at cycle 33, product_o=42; with BITS_PER_CYCLE=4 → done at cycle 9, product_o=42.
- Wrap: 0xFFFFFFFF × 2 → product_o=0xFFFFFFFE; 0x10000 × 0x10000 → 0x00000000.
- Reset mid-op: deassert rst_i at RUN cycle 10 → no mul_done_o pulse; a new MUL 3×5 then gives 15 after the full latency.
- MUL_EARLY_OUT_EN defined, MUL 0x1234 × 0 → mul_done_o at cycle 2, product_o=0; 5 × 1 → done at cycle 2, product_o=5.
